// File: rtl/fifo_to_ram_pkg.sv
// ---------------------------------------------------------------------------
// fifo_to_ram_pkg: shared helpers for the FIFO-to-RAM transfer engine.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_to_ram_pkg;

  function automatic int unsigned last_index(input int unsigned size);
    return (size == 0) ? 0 : size - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_to_ram_counter.sv
// ---------------------------------------------------------------------------
// fifo_to_ram_counter: wrapping 0..MAX-1 counter with clear and enable.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_to_ram_counter
  import fifo_to_ram_pkg::*;
#(
  parameter int W   = 16,
  parameter int MAX = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  localparam logic [W-1:0] LAST = W'(last_index(MAX));

  // High on the enabled cycle that carries the final value.
  assign last = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_to_ram.sv
// ---------------------------------------------------------------------------
// fifo_to_ram: pops DATA_SIZE FIFO words and writes them to RAM 0..N-1.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_to_ram
  import fifo_to_ram_pkg::*;
#(
  parameter int CW        = 16,
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int DATA_SIZE = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  output logic          fifo_pop,
  input  logic          fifo_empty,
  input  logic [DW-1:0] data_from_fifo,
  output logic          ram_wena,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] data_to_ram
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] LIMIT    = CW'(DATA_SIZE);
  localparam logic [CW-1:0] LAST_POP = CW'(last_index(DATA_SIZE));

  state_t        state;
  logic [CW-1:0] pop_cnt;
  logic [CW-1:0] wr_cnt;
  logic          last_wr;

  assign fifo_pop    = (state == RUN) && !fifo_empty && (pop_cnt < LIMIT);
  assign done        = (state == DONE);
  assign data_to_ram = data_from_fifo;
  assign ram_addr    = AW'(wr_cnt);

  // Clearing during DONE guarantees the next transfer starts at address 0.
  fifo_to_ram_counter #(
    .W   (CW),
    .MAX (DATA_SIZE)
  ) u_wr_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == DONE),
    .en   (ram_wena),
    .cnt  (wr_cnt),
    .last (last_wr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pop_cnt  <= '0;
      ram_wena <= 1'b0;
    end else begin
      ram_wena <= fifo_pop;
      case (state)
        IDLE: begin
          pop_cnt <= '0;
          if (start) state <= RUN;
        end
        RUN: begin
          if (fifo_pop) begin
            pop_cnt <= pop_cnt + CW'(1);
            if (pop_cnt == LAST_POP) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_wr) state <= DONE;
        end
        DONE: begin
          pop_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/fifo_to_ram.md
FIFO_TO_RAM -- requirements
Module: fifo_to_ram

Interface
REQ-001 SHALL have parameter CW, default 16, width of internal transfer counters.
REQ-002 SHALL have parameter AW, default 16, RAM address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter DATA_SIZE, default 1024, words per transfer (1 <= DATA_SIZE < 2^CW, DATA_SIZE <= 2^AW).
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle transfer request.
REQ-008 SHALL have port done  output  1  one-cycle pulse on transfer completion.
REQ-009 SHALL have port fifo_pop  output  1  FIFO read strobe.
REQ-010 SHALL have port fifo_empty  input  1  FIFO has no readable word.
REQ-011 SHALL have port data_from_fifo  input  DW  FIFO read data, valid the cycle after fifo_pop.
REQ-012 SHALL have port ram_wena  output  1  RAM write enable.
REQ-013 SHALL have port ram_addr  output  AW  RAM write address.
REQ-014 SHALL have port data_to_ram  output  DW  RAM write data.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-016 SHALL move IDLE->RUN on start=1; start SHALL be ignored in RUN, DRAIN and DONE.
REQ-017 In RUN, fifo_pop SHALL equal (fifo_empty==0) && (pop_cnt < DATA_SIZE); fifo_pop SHALL be 0 in all other states.
REQ-018 pop_cnt SHALL increment by 1 per cycle with fifo_pop=1; RUN->DRAIN on the cycle the DATA_SIZE-th pop is issued.
REQ-019 ram_wena SHALL be fifo_pop registered by exactly one cycle.
REQ-020 data_to_ram SHALL be combinational pass-through of data_from_fifo, aligned with ram_wena.
REQ-021 ram_addr SHALL be wr_cnt[AW-1:0], starting at 0; wr_cnt SHALL increment after each ram_wena cycle, giving addresses 0..DATA_SIZE-1 in order.
REQ-022 DRAIN->DONE on the cycle the final ram_wena (address DATA_SIZE-1) is asserted.
REQ-023 done SHALL be 1 for exactly one cycle, in DONE, which is the cycle after the final write; DONE->IDLE unconditionally.
REQ-024 pop_cnt and wr_cnt SHALL clear to 0 on entry to IDLE, so back-to-back transfers restart at address 0.
REQ-025 fifo_empty=1 mid-transfer SHALL stall pops without dropping, duplicating or reordering words.
REQ-026 Total pops and writes per transfer SHALL each be exactly DATA_SIZE; no pop SHALL be issued once pop_cnt==DATA_SIZE, even if fifo_empty=0.
REQ-027 DATA_SIZE=1 SHALL work: one pop, one write at address 0, done two cycles after the pop.

Reset
REQ-028 rst=1 SHALL asynchronously force state IDLE, pop_cnt=0, wr_cnt=0, fifo_pop=0, ram_wena=0, done=0, ram_addr=0.
REQ-029 rst mid-transfer SHALL abandon the transfer with no pending write issued after rst deasserts and no done pulse.

Structure
REQ-030 FSM state encodings SHALL be module-local localparams; no new shared-package constants are required.
REQ-031 The write-address counter SHALL reuse the existing counter sub-module (enable = ram_wena, MAX = DATA_SIZE).

Verification
REQ-032 DATA_SIZE=4, FIFO preloaded 0xA0..0xA3, start -> pops in cycles 1-4, writes addr 0..3 data A0..A3 in cycles 2-5, done in cycle 6 only.
REQ-033 DATA_SIZE=4, fifo_empty=1 for 3 cycles after second pop -> writes stall, order preserved, done one cycle after addr 3 write.
REQ-034 FIFO holds 6 words, DATA_SIZE=4 -> exactly 4 pops; 2 words remain; fifo_pop=0 after the fourth pop.
REQ-035 start pulsed again during RUN -> ignored; single done; second start after done -> new transfer restarts at addr 0.
REQ-036 rst asserted after 2 writes -> all outputs 0 immediately; no ram_wena or done after release until next start.
REQ-037 DATA_SIZE=1 -> one pop, one write at addr 0, done one cycle after the write.
